exe_stage: RTL

Execute stage of the five-stage in-order LoongArch32 pipeline. It sits between the decode stage (`ds_*`) and the memory stage (`ms_*`). The block latches one decoded instruction and computes its ALU, multiply or divide result, using an iterative 32-cycle divider. It issues the data-SRAM request for loads and stores, and exposes its destination and result to decode for hazard detection and forwarding.

---
 rtl/exe_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: ALU, single-cycle multiply, 32-iteration restoring divider,
// data-SRAM request generation and the EXE->MEM handshake.
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [167:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [75:0]  es_to_ms_bus,
  output logic         out_es_valid,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  logic         r_es_valid;
  logic [167:0] r_bus;
  div_state_t   r_state;
  logic [4:0]   r_cnt;
  logic [31:0]  r_rem;
  logic [31:0]  r_quo;
  logic [31:0]  r_dvs;

  logic [11:0] w_alu_op;
  logic [31:0] w_pc, w_rj, w_imm, w_rkd, w_src1, w_src2;
  logic [4:0]  w_dest;
  logic [3:0]  w_mem_we;
  logic [6:0]  w_divmul;
  logic [7:0]  w_ldst;
  logic        w_div_op, w_div_signed, w_ready_go, w_is_mem;

  assign w_alu_op     = r_bus[167:156];
  assign w_pc         = r_bus[154:123];
  assign w_rj         = r_bus[122:91];
  assign w_imm        = r_bus[89:58];
  assign w_rkd        = r_bus[57:26];
  assign w_dest       = r_bus[24:20];
  assign w_mem_we     = r_bus[18:15];
  assign w_divmul     = r_bus[14:8];
  assign w_ldst       = r_bus[7:0];
  assign w_src1       = r_bus[155] ? w_pc  : w_rj;
  assign w_src2       = r_bus[90]  ? w_imm : w_rkd;
  assign w_div_op     = |w_divmul[3:0];
  assign w_div_signed = w_divmul[3] | w_divmul[2];
  assign w_is_mem     = |w_ldst;

  assign w_ready_go     = ~w_div_op | (r_state == S_DONE);
  assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
  assign es_to_ms_valid = r_es_valid & w_ready_go;
  assign out_es_valid   = r_es_valid;

  always_ff @(posedge clk) begin
    if (reset)           r_es_valid <= 1'b0;
    else if (es_allowin) r_es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) r_bus <= ds_to_es_bus;
  end

  logic [31:0] w_alu_res;
  always_comb begin
    w_alu_res = '0;
    case (1'b1)
      w_alu_op[0]:  w_alu_res = w_src1 + w_src2;
      w_alu_op[1]:  w_alu_res = w_src1 - w_src2;
      w_alu_op[2]:  w_alu_res = {31'b0, $signed(w_src1) < $signed(w_src2)};
      w_alu_op[3]:  w_alu_res = {31'b0, w_src1 < w_src2};
      w_alu_op[4]:  w_alu_res = w_src1 & w_src2;
      w_alu_op[5]:  w_alu_res = ~(w_src1 | w_src2);
      w_alu_op[6]:  w_alu_res = w_src1 | w_src2;
      w_alu_op[7]:  w_alu_res = w_src1 ^ w_src2;
      w_alu_op[8]:  w_alu_res = w_src1 << w_src2[4:0];
      w_alu_op[9]:  w_alu_res = w_src1 >> w_src2[4:0];
      w_alu_op[10]: w_alu_res = $signed(w_src1) >>> w_src2[4:0];
      w_alu_op[11]: w_alu_res = w_src2;
      default:      w_alu_res = '0;
    endcase
  end

  // One 33x33 signed multiplier covers both signed and unsigned products.
  logic               w_mul_signed;
  logic signed [32:0] w_mul_a, w_mul_b;
  logic signed [63:0] w_mul_p;
  assign w_mul_signed = ~w_divmul[4];
  assign w_mul_a      = {w_mul_signed & w_rj[31],  w_rj};
  assign w_mul_b      = {w_mul_signed & w_rkd[31], w_rkd};
  assign w_mul_p      = w_mul_a * w_mul_b;

  logic [32:0] w_rem_sh;
  logic        w_sub_ok;
  logic [31:0] w_abs_rj, w_abs_rkd, w_q_fix, w_r_fix;
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_sub_ok  = w_rem_sh >= {1'b0, r_dvs};
  assign w_abs_rj  = (w_div_signed && w_rj[31])  ? -w_rj  : w_rj;
  assign w_abs_rkd = (w_div_signed && w_rkd[31]) ? -w_rkd : w_rkd;
  assign w_q_fix   = (w_div_signed && (w_rj[31] ^ w_rkd[31])) ? -r_quo : r_quo;
  assign w_r_fix   = (w_div_signed && w_rj[31]) ? -r_rem : r_rem;

  // r_quo starts as the dividend and shifts quotient bits in from the right.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: if (r_es_valid && w_div_op) begin
          r_state <= S_RUN;
          r_cnt   <= 5'd0;
          r_rem   <= 32'd0;
          r_quo   <= w_abs_rj;
          r_dvs   <= w_abs_rkd;
        end
        S_RUN: begin
          r_rem <= w_sub_ok ? (w_rem_sh[31:0] - r_dvs) : w_rem_sh[31:0];
          r_quo <= {r_quo[30:0], w_sub_ok};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        S_DONE: if (ms_allowin) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [31:0] w_es_result;
  always_comb begin
    if (w_is_mem)                        w_es_result = w_rj + w_imm;
    else if (w_divmul[6])                w_es_result = w_mul_p[31:0];
    else if (w_divmul[5] | w_divmul[4])  w_es_result = w_mul_p[63:32];
    else if (w_divmul[3] | w_divmul[1])  w_es_result = w_q_fix;
    else if (w_divmul[2] | w_divmul[0])  w_es_result = w_r_fix;
    else                                 w_es_result = w_alu_res;
  end

  logic [1:0] w_ofs;
  assign w_ofs = w_ldst[1] ? {w_es_result[1], 1'b0} : w_es_result[1:0];

  assign data_sram_en   = r_es_valid & ms_allowin & w_is_mem;
  assign data_sram_addr = w_es_result;
  assign data_sram_we   = r_es_valid ? (w_mem_we << w_ofs) : 4'b0;

  always_comb begin
    data_sram_wdata = w_rkd;
    if (w_ldst[2])      data_sram_wdata = {4{w_rkd[7:0]}};
    else if (w_ldst[1]) data_sram_wdata = {2{w_rkd[15:0]}};
  end

  assign es_to_ms_bus = {w_ldst[7:3], r_bus[19], r_bus[25], w_dest, w_es_result, w_pc};

endmodule
